// File: rtl/pp_pkg.sv
// Shared encodings for the pP core front end: instruction classes and branch conditions.
// Latency: n/a (constants only).
// Backpressure: n/a.
package pp_pkg;

  // Instruction classes decoded from the 4-bit kind field
  localparam logic [3:0] KIND_BR   = 4'b0100;
  localparam logic [3:0] KIND_JMP  = 4'b0101;
  localparam logic [3:0] KIND_JSB  = 4'b0110;
  localparam logic [3:0] KIND_RET  = 4'b0111;
  localparam logic [3:0] KIND_RETI = 4'b1000;
  localparam logic [3:0] KIND_ENAI = 4'b1001;
  localparam logic [3:0] KIND_DISI = 4'b1010;

  // Branch condition selects carried in fn2
  localparam logic [1:0] FN_BZ  = 2'b00;
  localparam logic [1:0] FN_BNZ = 2'b01;
  localparam logic [1:0] FN_BC  = 2'b10;
  localparam logic [1:0] FN_BNC = 2'b11;

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO of DEPTH entries; pushes when full and pops when empty are ignored.
// Latency: push/pop take effect on the next edge; top/full/empty/count reflect registered state.
// Backpressure: none; the caller gates push/pop (e.g. on stall) and reads full/empty.
// Ports: clk, rst_n (sync, active low); push/din, pop; full, empty, top, count (0..DEPTH).
module ret_stack #(
  parameter int W     = 12,
  parameter int DEPTH = 8,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic          full,
  output logic          empty,
  output logic [W-1:0]  top,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-2:0] ONE_IDX  = (CW-1)'(1);

  logic [W-1:0]  mem [DEPTH];
  logic [CW-1:0] cnt;
  logic [CW-2:0] top_idx;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  // At cnt == DEPTH the low bits are zero, so the decrement wraps to DEPTH-1.
  assign top_idx = cnt[CW-2:0] - ONE_IDX;
  assign top     = mem[top_idx];
  assign count   = cnt;

  // Push takes priority if both are requested in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty && !push;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (do_push) begin
      cnt <= cnt + CW'(1);
    end else if (do_pop) begin
      cnt <= cnt - CW'(1);
    end
  end

  // Contents need no reset: the count alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[cnt[CW-2:0]] <= din;
    end
  end

endmodule

// File: rtl/pc_seq.sv
// Registered PC sequencer: branches, jumps, subroutine stack, prioritised vectored interrupts.
// Latency: 1 cycle from kind/fn2/cc/disp/addr/irq_n to pc, irq_ack and flags.
// Backpressure: stall=1 freezes all state and blocks interrupt acceptance; err_clr still acts.
// Ports: clk, rst_n; stall, kind, fn2, cc_z, cc_c, disp, addr, irq_n, err_clr in;
//        pc, irq_ack, int_en, in_service, sp, ovf, unf out.
module pc_seq
  import pp_pkg::*;
#(
  parameter int            AW         = 12,
  parameter int            DEPTH      = 8,
  parameter int            NUM_IRQ    = 4,
  parameter logic [AW-1:0] VEC_BASE   = AW'(1),
  parameter logic [AW-1:0] RESET_ADDR = '0,
  localparam int           SPW        = $clog2(DEPTH) + 1,
  localparam int           IW         = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic [3:0]         kind,
  input  logic [1:0]         fn2,
  input  logic               cc_z,
  input  logic               cc_c,
  input  logic [AW-1:0]      disp,
  input  logic [AW-1:0]      addr,
  input  logic [NUM_IRQ-1:0] irq_n,
  input  logic               err_clr,
  output logic [AW-1:0]      pc,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic               int_en,
  output logic               in_service,
  output logic [SPW-1:0]     sp,
  output logic               ovf,
  output logic               unf
);

  logic [AW-1:0] int_pc;
  logic [AW-1:0] seq;
  logic [AW-1:0] next_pc;
  logic [AW-1:0] stk_top;
  logic          stk_full;
  logic          stk_empty;
  logic          br_taken;
  logic          do_push;
  logic          do_pop;
  logic          ovf_set;
  logic          unf_set;
  logic          reti_exit;
  logic          int_en_nxt;
  logic          irq_any;
  logic [IW-1:0] irq_idx;
  logic          accept;

  assign seq = pc + AW'(1);

  always_comb begin
    br_taken = 1'b0;
    case (fn2)
      FN_BZ:   br_taken = cc_z;
      FN_BNZ:  br_taken = !cc_z;
      FN_BC:   br_taken = cc_c;
      FN_BNC:  br_taken = !cc_c;
      default: br_taken = 1'b0;
    endcase
  end

  // Next address and side effects of the instruction at pc, ignoring interrupts.
  always_comb begin
    next_pc    = seq;
    do_push    = 1'b0;
    do_pop     = 1'b0;
    ovf_set    = 1'b0;
    unf_set    = 1'b0;
    reti_exit  = 1'b0;
    int_en_nxt = int_en;
    case (kind)
      KIND_BR:   if (br_taken) next_pc = pc + disp;
      KIND_JMP:  next_pc = addr;
      KIND_JSB: begin
        next_pc = addr;
        if (stk_full) ovf_set = 1'b1;
        else          do_push = 1'b1;
      end
      KIND_RET: begin
        if (stk_empty) begin
          unf_set = 1'b1;
        end else begin
          do_pop  = 1'b1;
          next_pc = stk_top;
        end
      end
      KIND_RETI: begin
        if (in_service) begin
          next_pc   = int_pc;
          reti_exit = 1'b1;
        end else begin
          unf_set = 1'b1;
        end
      end
      KIND_ENAI: int_en_nxt = 1'b1;
      KIND_DISI: int_en_nxt = 1'b0;
      default: ;
    endcase
  end

  // Lowest-index asserted request wins: scan downward so the last hit is the smallest index.
  always_comb begin
    irq_any = 1'b0;
    irq_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (!irq_n[i]) begin
        irq_any = 1'b1;
        irq_idx = IW'(i);
      end
    end
  end

  // Uses the registered int_en, so a same-cycle ENAI/DISI does not affect this decision.
  // A RETI leaving the handler releases in_service now, allowing back-to-back entry.
  assign accept = !stall && int_en && (!in_service || reti_exit) && irq_any;

  ret_stack #(
    .W     (AW),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (do_push && !stall),
    .pop   (do_pop && !stall),
    .din   (seq),
    .full  (stk_full),
    .empty (stk_empty),
    .top   (stk_top),
    .count (sp)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc         <= RESET_ADDR;
      int_pc     <= '0;
      int_en     <= 1'b0;
      in_service <= 1'b0;
      irq_ack    <= '0;
      ovf        <= 1'b0;
      unf        <= 1'b0;
    end else begin
      // A set in the same cycle beats err_clr; err_clr works even while stalled.
      if (ovf_set && !stall) ovf <= 1'b1;
      else if (err_clr)      ovf <= 1'b0;
      if (unf_set && !stall) unf <= 1'b1;
      else if (err_clr)      unf <= 1'b0;

      if (stall) begin
        irq_ack <= '0;
      end else begin
        int_en <= int_en_nxt;
        if (accept) begin
          pc         <= VEC_BASE + AW'(irq_idx);
          int_pc     <= next_pc;
          in_service <= 1'b1;
          irq_ack    <= NUM_IRQ'(1) << irq_idx;
        end else begin
          pc      <= next_pc;
          irq_ack <= '0;
          if (reti_exit) in_service <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_seq.sv
// Self-checking bench for pc_seq: vector table plus hand-written multi-cycle sequences.
// Latency: each step drives inputs, waits one edge, compares the queued expectation.
// Backpressure: exercised via stall steps in the sequences.
module tb_pc_seq;
  import pp_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, stall, cc_z, cc_c, err_clr;
  logic [3:0]  kind;
  logic [1:0]  fn2;
  logic [11:0] disp, addr, pc;
  logic [3:0]  irq_n, irq_ack, sp;
  logic        int_en, in_service, ovf, unf;

  pc_seq #(
    .AW(12), .DEPTH(8), .NUM_IRQ(4), .VEC_BASE(12'h001), .RESET_ADDR(12'h000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .kind(kind), .fn2(fn2),
    .cc_z(cc_z), .cc_c(cc_c), .disp(disp), .addr(addr), .irq_n(irq_n),
    .err_clr(err_clr), .pc(pc), .irq_ack(irq_ack), .int_en(int_en),
    .in_service(in_service), .sp(sp), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic [3:0]  k;
    logic [1:0]  f;
    logic        z, c;
    logic [11:0] d, a;
    logic [3:0]  irq;
    logic        st, ec;
  } in_t;

  typedef struct {
    logic [11:0] pc;
    logic [3:0]  ack;
    logic        ie, insv;
    logic [3:0]  sp;
    logic        ovf, unf;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t e;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;

  function automatic in_t mi(input logic r, input logic [3:0] k, input logic [1:0] f,
                             input logic z, input logic c, input logic [11:0] d,
                             input logic [11:0] a, input logic [3:0] irq,
                             input logic st, input logic ec);
    in_t t;
    t.r = r; t.k = k; t.f = f; t.z = z; t.c = c; t.d = d; t.a = a;
    t.irq = irq; t.st = st; t.ec = ec;
    return t;
  endfunction

  function automatic exp_t mexp(input logic [11:0] p, input logic [3:0] ack,
                                input logic ie, input logic insv, input logic [3:0] s,
                                input logic o, input logic u);
    exp_t t;
    t.pc = p; t.ack = ack; t.ie = ie; t.insv = insv; t.sp = s; t.ovf = o; t.unf = u;
    return t;
  endfunction

  function automatic vec_t mv(input in_t i, input exp_t e);
    vec_t v;
    v.i = i; v.e = e;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, step_no, act, expv);
    end
  endtask

  task automatic step(input in_t i, input exp_t e);
    exp_t x;
    rst_n = i.r; kind = i.k; fn2 = i.f; cc_z = i.z; cc_c = i.c;
    disp = i.d; addr = i.a; irq_n = i.irq; stall = i.st; err_clr = i.ec;
    sb.push_back(e);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk("pc", 32'(pc), 32'(x.pc));
    chk("irq_ack", 32'(irq_ack), 32'(x.ack));
    chk("int_en", 32'(int_en), 32'(x.ie));
    chk("in_service", 32'(in_service), 32'(x.insv));
    chk("sp", 32'(sp), 32'(x.sp));
    chk("ovf", 32'(ovf), 32'(x.ovf));
    chk("unf", 32'(unf), 32'(x.unf));
    step_no++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[15];
    logic [11:0] stk[$];
    logic [11:0] p, tgt;
    logic        uf;

    // Reset, sequencing and branch conditions: pc changes only, flags stay clear.
    tbl[0]  = mv(mi(0, 4'b0000, 0, 0, 0, 0, 0, 4'hF, 0, 0), mexp(12'h000, 0, 0, 0, 0, 0, 0));
    tbl[1]  = mv(mi(1, 4'b0000, 0, 0, 0, 0, 0, 4'hF, 0, 0), mexp(12'h001, 0, 0, 0, 0, 0, 0));
    tbl[2]  = mv(mi(1, 4'b0000, 0, 0, 0, 0, 0, 4'hF, 0, 0), mexp(12'h002, 0, 0, 0, 0, 0, 0));
    tbl[3]  = mv(mi(1, 4'b0000, 0, 0, 0, 0, 0, 4'hF, 0, 0), mexp(12'h003, 0, 0, 0, 0, 0, 0));
    tbl[4]  = mv(mi(1, KIND_JMP, 0, 0, 0, 0, 12'h010, 4'hF, 0, 0), mexp(12'h010, 0, 0, 0, 0, 0, 0));
    tbl[5]  = mv(mi(1, KIND_BR, FN_BZ, 1, 0, 12'hFF0, 0, 4'hF, 0, 0), mexp(12'h000, 0, 0, 0, 0, 0, 0));
    tbl[6]  = mv(mi(1, KIND_JMP, 0, 0, 0, 0, 12'h010, 4'hF, 0, 0), mexp(12'h010, 0, 0, 0, 0, 0, 0));
    tbl[7]  = mv(mi(1, KIND_BR, FN_BZ, 0, 0, 12'hFF0, 0, 4'hF, 0, 0), mexp(12'h011, 0, 0, 0, 0, 0, 0));
    tbl[8]  = mv(mi(1, KIND_BR, FN_BNZ, 0, 0, 12'h005, 0, 4'hF, 0, 0), mexp(12'h016, 0, 0, 0, 0, 0, 0));
    tbl[9]  = mv(mi(1, KIND_BR, FN_BC, 0, 0, 12'h005, 0, 4'hF, 0, 0), mexp(12'h017, 0, 0, 0, 0, 0, 0));
    tbl[10] = mv(mi(1, KIND_BR, FN_BNC, 0, 0, 12'h002, 0, 4'hF, 0, 0), mexp(12'h019, 0, 0, 0, 0, 0, 0));
    tbl[11] = mv(mi(1, KIND_BR, FN_BC, 0, 1, 12'hFFF, 0, 4'hF, 0, 0), mexp(12'h018, 0, 0, 0, 0, 0, 0));
    tbl[12] = mv(mi(1, 4'b1111, 0, 0, 0, 0, 12'h3AB, 4'hF, 0, 0), mexp(12'h019, 0, 0, 0, 0, 0, 0));
    tbl[13] = mv(mi(1, 4'b0011, 0, 0, 0, 0, 12'h3AB, 4'hF, 0, 0), mexp(12'h01A, 0, 0, 0, 0, 0, 0));
    tbl[14] = mv(mi(1, KIND_JMP, 0, 0, 0, 0, 12'h018, 4'hF, 0, 0), mexp(12'h018, 0, 0, 0, 0, 0, 0));

    for (int n = 0; n < 15; n++) step(tbl[n].i, tbl[n].e);

    // Nine JSBs into an 8-deep stack: the ninth is dropped and sets ovf.
    p = 12'h018;
    for (int k = 0; k < 9; k++) begin
      tgt = 12'h100 + 12'(16 * k);
      if (stk.size() < 8) stk.push_back(p + 12'd1);
      step(mi(1, KIND_JSB, 0, 0, 0, 0, tgt, 4'hF, 0, 0),
           mexp(tgt, 0, 0, 0, 4'(stk.size()), (k == 8), 0));
      p = tgt;
    end
    // Nine RETs: eight return addresses in reverse, the ninth underflows to pc+1.
    for (int k = 0; k < 9; k++) begin
      if (stk.size() > 0) begin
        tgt = stk.pop_back();
        uf  = 1'b0;
      end else begin
        tgt = p + 12'd1;
        uf  = 1'b1;
      end
      step(mi(1, KIND_RET, 0, 0, 0, 0, 0, 4'hF, 0, 0), mexp(tgt, 0, 0, 0, 4'(stk.size()), 1, uf));
      p = tgt;
    end

    // Stall freezes pc and flags; err_clr still clears during stall; a same-cycle set beats err_clr.
    step(mi(1, KIND_JMP, 0, 0, 0, 0, 12'h555, 4'hF, 1, 0), mexp(12'h01A, 0, 0, 0, 0, 1, 1));
    step(mi(1, KIND_JMP, 0, 0, 0, 0, 12'h555, 4'hF, 1, 1), mexp(12'h01A, 0, 0, 0, 0, 0, 0));
    step(mi(1, KIND_RET, 0, 0, 0, 0, 0, 4'hF, 0, 1), mexp(12'h01B, 0, 0, 0, 0, 0, 1));
    step(mi(1, 4'b0000, 0, 0, 0, 0, 0, 4'hF, 0, 1), mexp(12'h01C, 0, 0, 0, 0, 0, 0));

    // Interrupt priority, masking while in service, stall blocking, and return.
    step(mi(1, KIND_ENAI, 0, 0, 0, 0, 0, 4'hF, 0, 0), mexp(12'h01D, 0, 1, 0, 0, 0, 0));
    step(mi(1, KIND_JMP, 0, 0, 0, 0, 12'h200, 4'b1001, 0, 0), mexp(12'h002, 4'b0010, 1, 1, 0, 0, 0));
    step(mi(1, 4'b0000, 0, 0, 0, 0, 0, 4'b1001, 0, 0), mexp(12'h003, 0, 1, 1, 0, 0, 0));
    step(mi(1, 4'b0000, 0, 0, 0, 0, 0, 4'b1001, 1, 0), mexp(12'h003, 0, 1, 1, 0, 0, 0));
    step(mi(1, KIND_RETI, 0, 0, 0, 0, 0, 4'hF, 0, 0), mexp(12'h200, 0, 1, 0, 0, 0, 0));
    step(mi(1, 4'b0000, 0, 0, 0, 0, 0, 4'b1110, 1, 0), mexp(12'h200, 0, 1, 0, 0, 0, 0));
    step(mi(1, 4'b0000, 0, 0, 0, 0, 0, 4'b1110, 0, 0), mexp(12'h001, 4'b0001, 1, 1, 0, 0, 0));
    // RETI with a pending request re-enters straight away, saving the RETI target.
    step(mi(1, KIND_RETI, 0, 0, 0, 0, 0, 4'b1011, 0, 0), mexp(12'h003, 4'b0100, 1, 1, 0, 0, 0));
    step(mi(1, KIND_RETI, 0, 0, 0, 0, 0, 4'hF, 0, 0), mexp(12'h201, 0, 1, 0, 0, 0, 0));
    // Same-cycle DISI does not block acceptance.
    step(mi(1, KIND_DISI, 0, 0, 0, 0, 0, 4'b0111, 0, 0), mexp(12'h004, 4'b1000, 0, 1, 0, 0, 0));
    step(mi(1, KIND_RETI, 0, 0, 0, 0, 0, 4'hF, 0, 0), mexp(12'h202, 0, 0, 0, 0, 0, 0));
    // Same-cycle ENAI does not enable acceptance.
    step(mi(1, KIND_ENAI, 0, 0, 0, 0, 0, 4'b1110, 0, 0), mexp(12'h203, 0, 1, 0, 0, 0, 0));
    // RETI outside a handler falls through and flags unf.
    step(mi(1, KIND_RETI, 0, 0, 0, 0, 0, 4'hF, 0, 0), mexp(12'h204, 0, 1, 0, 0, 0, 1));
    step(mi(1, 4'b0000, 0, 0, 0, 0, 0, 4'hF, 0, 1), mexp(12'h205, 0, 1, 0, 0, 0, 0));

    // Build up sp=3, ovf=1, in_service=1, then reset mid-operation.
    p = 12'h205;
    stk.delete();
    for (int k = 0; k < 9; k++) begin
      tgt = 12'h300 + 12'(16 * k);
      if (stk.size() < 8) stk.push_back(p + 12'd1);
      step(mi(1, KIND_JSB, 0, 0, 0, 0, tgt, 4'hF, 0, 0),
           mexp(tgt, 0, 1, 0, 4'(stk.size()), (k == 8), 0));
      p = tgt;
    end
    for (int k = 0; k < 5; k++) begin
      tgt = stk.pop_back();
      step(mi(1, KIND_RET, 0, 0, 0, 0, 0, 4'hF, 0, 0), mexp(tgt, 0, 1, 0, 4'(stk.size()), 1, 0));
    end
    step(mi(1, 4'b0000, 0, 0, 0, 0, 0, 4'b1110, 0, 0), mexp(12'h001, 4'b0001, 1, 1, 3, 1, 0));
    step(mi(0, KIND_JSB, 0, 0, 0, 0, 12'h777, 4'b0000, 1, 0), mexp(12'h000, 0, 0, 0, 0, 0, 0));
    step(mi(1, 4'b0000, 0, 0, 0, 0, 0, 4'hF, 0, 0), mexp(12'h001, 0, 0, 0, 0, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_seq.md
Name: pc_seq

Overview:
- Registered program-counter sequencer for the pP core; the successor to the combinational next-address mux.
- Owns the PC, an internal return-address stack, the interrupt-enable flag, the saved interrupt PC and the in-service flag.
- Accepts multiple prioritised active-low interrupt requests.
- Sits between instruction decode (kind/fn2/target) and instruction memory address.

Parameters:
- AW, 12, address width in bits.
- DEPTH, 8, return-stack entries (power of two, >=2).
- NUM_IRQ, 4, interrupt request channels (1..8).
- VEC_BASE, 1, address of the channel-0 vector; channel i vectors to VEC_BASE+i (mod 2^AW).
- RESET_ADDR, 0, PC value after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- stall  in  1  hold all state this cycle.
- kind  in  4  instruction class of the instruction at pc.
- fn2  in  2  branch condition select.
- cc_z  in  1  zero flag.
- cc_c  in  1  carry flag.
- disp  in  AW  branch displacement, two's complement.
- addr  in  AW  absolute JMP/JSB target.
- irq_n  in  NUM_IRQ  interrupt requests, active low, level.
- err_clr  in  1  clears sticky error flags.
- pc  out  AW  current instruction address, registered.
- irq_ack  out  NUM_IRQ  one-hot, one-cycle acknowledge of the accepted channel.
- int_en  out  1  interrupt-enable flag.
- in_service  out  1  interrupt handler active.
- sp  out  log2(DEPTH)+1  stack occupancy, 0..DEPTH.
- ovf  out  1  sticky stack overflow.
- unf  out  1  sticky stack underflow / RETI-outside-handler.

Behaviour:
- Reset: when rst_n=0 at a rising edge:
  - pc=RESET_ADDR.
  - sp=0, stack contents don't-care.
  - int_en=0, in_service=0, int_pc=0.
  - irq_ack=0, ovf=0, unf=0.
- Reset overrides stall and all other inputs.
- Timing: kind/fn2/cc/disp/addr describe the instruction at the current pc; the result is registered on the next edge. Latency is 1 cycle.
- Stall=1: pc, sp, stack, flags and int_pc all hold; irq_ack=0; no interrupt is accepted. err_clr is still honoured.
- Next-address computation (seq = pc+1, all arithmetic mod 2^AW):
  - kind 0100, branch; target = pc+disp.
    - fn2 00 bz: taken if cc_z=1.
    - fn2 01 bnz: taken if cc_z=0.
    - fn2 10 bc: taken if cc_c=1.
    - fn2 11 bnc: taken if cc_c=0.
    - Not taken: seq.
  - kind 0101 JMP: addr.
  - kind 0110 JSB: addr, and push seq.
    - Stack full (sp=DEPTH): push is dropped, ovf<=1, jump still happens.
  - kind 0111 RET: pop top of stack.
    - Stack empty: next=seq, unf<=1, sp stays 0.
  - kind 1000 RETI:
    - in_service=1: next=int_pc, in_service<=0.
    - in_service=0: next=seq, unf<=1.
  - kind 1001 ENAI: int_en<=1, next=seq.
  - kind 1010 DISI: int_en<=0, next=seq.
  - Any other kind: seq.
- Interrupt acceptance (not stalled, not in reset): int_en=1 AND in_service=0 AND any irq_n bit=0.
  - The lowest-index asserted channel wins.
  - The current instruction completes fully: stack push/pop, flag changes and RETI effects all take place.
  - Its computed next address goes to int_pc.
  - pc<=VEC_BASE+i, in_service<=1, irq_ack[i]=1 for exactly one cycle.
  - The same-cycle ENAI does not enable acceptance in that cycle; evaluation uses the registered int_en.
  - A same-cycle DISI does not block acceptance in that cycle.
  - A RETI in the same cycle clears and re-sets in_service; the new int_pc is the RETI target, giving back-to-back handler entry.
- No nesting: requests are ignored while in_service=1.
- Stack pointer: sp increments on a successful push and decrements on a successful pop. It never wraps past 0 or DEPTH.
- Sticky flags: ovf and unf are cleared by err_clr, but a same-cycle set wins over the clear.

Decomposition:
- Shared package pp_pkg holds:
  - kind codes: KIND_BR, KIND_JMP, KIND_JSB, KIND_RET, KIND_RETI, KIND_ENAI, KIND_DISI.
  - fn2 codes: FN_BZ, FN_BNZ, FN_BC, FN_BNC.
- One sub-module, ret_stack: DEPTH-entry LIFO with push, pop, full, empty, top and count. It has the same clk/rst_n and guards its own overflow/underflow. pc_seq instantiates it.

Test Plan:
- Reset sequencing: reset with RESET_ADDR=0, kind=0000 for 3 cycles -> pc=0,1,2,3; int_en=0, sp=0.
- Branches: pc=0x010, kind=0100, fn2=00, cc_z=1, disp=0xFF0 -> pc=0x000. Repeat with cc_z=0 -> pc=0x011.
- Stack depth and overflow: nine JSB to 0x100 from DEPTH=8 -> sp saturates at 8, ovf=1 after the 9th. Then nine RETs -> pops return the addresses in reverse, the 9th RET gives pc+1 and unf=1. err_clr -> both flags 0.
- Interrupt priority and return: ENAI, then irq_n=4'b1001 (ch1, ch2 low) during a JMP to 0x200 -> irq_ack=0010, pc=VEC_BASE+1=0x002, in_service=1. Later RETI -> pc=0x200, in_service=0.
- Masking: int_en=1, irq held low while in_service=1 -> no irq_ack. Stall=1 with pending irq and int_en=1 -> pc frozen, no ack until stall=0.
- Reset mid-operation: rst_n=0 while in_service=1, sp=3, ovf=1 -> all outputs return to reset values on the next edge.
